// File: rtl/alu_iter_pkg.sv
// Shared types for the iterative ALU: opcodes, FSM states, decode helper.
// ALU_ITER_MUL_EN adds the MUL opcode and the MUL state.
package alu_iter_pkg;

  typedef enum logic [7:0] {
    OP_ADD  = 8'h00,
    OP_ADDC = 8'h01,
    OP_SUB  = 8'h02,
    OP_SUBC = 8'h03,
    OP_CMP  = 8'h04,
    OP_AND  = 8'h05,
    OP_OR   = 8'h06,
    OP_NEG  = 8'h07,
    OP_LSL  = 8'h08,
    OP_LSR  = 8'h09,
    OP_LSLC = 8'h0A,
    OP_LSRC = 8'h0B,
    OP_ASR  = 8'h0C,
`ifdef ALU_ITER_MUL_EN
    OP_MUL  = 8'h0D,
`endif
    OP_IMME = 8'h10,
    OP_BEQ  = 8'h11,
    OP_BNE  = 8'h12,
    OP_JMP  = 8'h13,
    OP_LW   = 8'h14,
    OP_SW   = 8'h15,
    OP_HALT = 8'hFF
  } op_code;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
`ifdef ALU_ITER_MUL_EN
    MUL   = 2'd2,
`endif
    DONE  = 2'd3
  } alu_state_t;

  function automatic logic is_shift(op_code op);
    return op inside {OP_LSL, OP_LSR, OP_LSLC,
                      OP_LSRC, OP_ASR};
  endfunction

endpackage

// File: rtl/alu_flags.sv
// Architectural C/N/Z register. A DONE update beats a
// same-cycle clear; a clear alone zeroes all three flags.
module alu_flags
(
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic upd_c_i,
  input  logic upd_nz_i,
  input  logic c_i,
  input  logic n_i,
  input  logic z_i,
  output logic c_o,
  output logic n_o,
  output logic z_o
);

  logic c_q, n_q, z_q;
  logic c_d, n_d, z_d;

  always_comb begin
    c_d = c_q;
    n_d = n_q;
    z_d = z_q;
    if (upd_c_i || upd_nz_i) begin
      if (upd_c_i) c_d = c_i;
      if (upd_nz_i) begin
        n_d = n_i;
        z_d = z_i;
      end
    end else if (clr_i) begin
      c_d = 1'b0;
      n_d = 1'b0;
      z_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c_q <= 1'b0;
      n_q <= 1'b0;
      z_q <= 1'b0;
    end else begin
      c_q <= c_d;
      n_q <= n_d;
      z_q <= z_d;
    end
  end

  assign c_o = c_q;
  assign n_o = n_q;
  assign z_o = z_q;

endmodule

// File: rtl/alu_iter.sv
// Sequential ALU with carry flags and bit-serial shifts.
// Optional serial multiplier under ALU_ITER_MUL_EN.
module alu_iter
  import alu_iter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH) + 1
)
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  op_code           op_i,
  input  logic [WIDTH-1:0] rs_i,
  input  logic [WIDTH-1:0] rt_i,
  input  logic             flag_clr_i,
  output logic             ready_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             res_we_o,
  output logic             carry_o,
  output logic             neg_o,
  output logic             zero_o
);

  alu_state_t       state_q, state_d;
  op_code           op_q, op_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             cy_q, cy_d;
  logic             fill_q, fill_d;
  logic             upd_c_q, upd_c_d;
  logic             upd_nz_q, upd_nz_d;
  logic             we_q, we_d;
  logic             cin;
  logic [SHW-1:0]   amt;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;

`ifdef ALU_ITER_MUL_EN
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
`endif

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    cy_d     = cy_q;
    fill_d   = fill_q;
    upd_c_d  = upd_c_q;
    upd_nz_d = upd_nz_q;
    we_d     = we_q;
`ifdef ALU_ITER_MUL_EN
    mcand_d  = mcand_q;
    prod_d   = prod_q;
    mplier_d = mplier_q;
`endif
    // a same-cycle clear must already be visible as carry-in
    cin  = flag_clr_i ? 1'b0 : carry_o;
    amt  = (rt_i >= WIDTH'(WIDTH)) ? SHW'(WIDTH)
                                   : SHW'(rt_i);
    sum  = {1'b0, rs_i} + {1'b0, rt_i}
         + {{WIDTH{1'b0}}, cin & (op_i == OP_ADDC)};
    diff = {1'b0, rs_i} - {1'b0, rt_i}
         - {{WIDTH{1'b0}}, cin & (op_i == OP_SUBC)};

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          op_d     = op_i;
          state_d  = DONE;
          upd_c_d  = 1'b0;
          upd_nz_d = 1'b1;
          we_d     = 1'b1;
          unique case (op_i)
            OP_ADD, OP_ADDC: begin
              {cy_d, acc_d} = sum;
              upd_c_d       = 1'b1;
            end
            OP_SUB, OP_SUBC, OP_CMP: begin
              {cy_d, acc_d} = diff;
              upd_c_d       = 1'b1;
              we_d          = (op_i != OP_CMP);
            end
            OP_AND: acc_d = rs_i & rt_i;
            OP_OR:  acc_d = rs_i | rt_i;
            OP_NEG: acc_d = ~rt_i;
`ifdef ALU_ITER_MUL_EN
            OP_MUL: begin
              mcand_d  = {{WIDTH{1'b0}}, rs_i};
              mplier_d = rt_i;
              prod_d   = '0;
              cnt_d    = SHW'(WIDTH);
              upd_c_d  = 1'b1;
              state_d  = MUL;
            end
`endif
            default: begin
              if (is_shift(op_i)) begin
                acc_d  = rs_i;
                cnt_d  = amt;
                fill_d = cin & (op_i inside {OP_LSLC, OP_LSRC});
                if (amt != '0) begin
                  upd_c_d = 1'b1;
                  state_d = SHIFT;
                end
              end else begin
                acc_d    = '0;
                upd_nz_d = 1'b0;
                we_d     = 1'b0;
              end
            end
          endcase
        end
      end
      SHIFT: begin
        cnt_d = cnt_q - 1'b1;
        if (op_q inside {OP_LSL, OP_LSLC}) begin
          cy_d  = acc_q[WIDTH-1];
          acc_d = {acc_q[WIDTH-2:0], fill_q};
        end else if (op_q == OP_ASR) begin
          cy_d  = acc_q[0];
          acc_d = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
        end else begin
          cy_d  = acc_q[0];
          acc_d = {fill_q, acc_q[WIDTH-1:1]};
        end
        if (cnt_d == '0) state_d = DONE;
      end
`ifdef ALU_ITER_MUL_EN
      MUL: begin
        prod_d   = prod_q + (mplier_q[0] ? mcand_q : '0);
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - 1'b1;
        if (cnt_d == '0) begin
          acc_d   = prod_d[WIDTH-1:0];
          cy_d    = |prod_d[2*WIDTH-1:WIDTH];
          state_d = DONE;
        end
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    result_d = result_q;
    if (state_d == DONE && state_q != DONE)
      result_d = acc_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= OP_ADD;
      acc_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      cy_q     <= 1'b0;
      fill_q   <= 1'b0;
      upd_c_q  <= 1'b0;
      upd_nz_q <= 1'b0;
      we_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      cy_q     <= cy_d;
      fill_q   <= fill_d;
      upd_c_q  <= upd_c_d;
      upd_nz_q <= upd_nz_d;
      we_q     <= we_d;
    end
  end

`ifdef ALU_ITER_MUL_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand_q  <= '0;
      prod_q   <= '0;
      mplier_q <= '0;
    end else begin
      mcand_q  <= mcand_d;
      prod_q   <= prod_d;
      mplier_q <= mplier_d;
    end
  end
`endif

  assign ready_o  = (state_q == IDLE);
  assign done_o   = (state_q == DONE);
  assign res_we_o = done_o & we_q;
  assign result_o = result_q;

  alu_flags u_flags (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (flag_clr_i),
    .upd_c_i  (done_o & upd_c_q),
    .upd_nz_i (done_o & upd_nz_q),
    .c_i      (cy_q),
    .n_i      (result_q[WIDTH-1]),
    .z_i      (result_q == '0),
    .c_o      (carry_o),
    .n_o      (neg_o),
    .z_o      (zero_o)
  );

endmodule

// File: tb/tb_alu_iter.sv
// Self-checking bench for alu_iter: directed table, corner
// sequences, and random ops against an arithmetic model.
module tb_alu_iter;
  import alu_iter_pkg::*;

  localparam int W    = 8;
  localparam int MASK = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start_i = 1'b0;
  op_code       op_i = OP_ADD;
  logic [W-1:0] rs_i = '0;
  logic [W-1:0] rt_i = '0;
  logic         flag_clr_i = 1'b0;
  logic         ready_o, done_o, res_we_o;
  logic [W-1:0] result_o;
  logic         carry_o, neg_o, zero_o;

  int checks = 0;
  int errors = 0;
  bit m_c = 0, m_n = 0, m_z = 0;

  alu_iter #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start_i    (start_i),
    .op_i       (op_i),
    .rs_i       (rs_i),
    .rt_i       (rt_i),
    .flag_clr_i (flag_clr_i),
    .ready_o    (ready_o),
    .done_o     (done_o),
    .result_o   (result_o),
    .res_we_o   (res_we_o),
    .carry_o    (carry_o),
    .neg_o      (neg_o),
    .zero_o     (zero_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    op_code op;
    int     rs;
    int     rt;
    bit     clr;
    int     res;
    bit     c;
    bit     n;
    bit     z;
    bit     we;
    int     lat;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, exp);
    end
  endtask

  // Reference: architectural rules with plain integer math.
  task automatic model_op(input op_code op, input int rs,
                          input int rt, input bit clr,
                          output int r, output bit we,
                          output int lat);
    int amt, s;
    bit cin, fill, rec;
    if (clr) begin m_c = 0; m_n = 0; m_z = 0; end
    cin = m_c;
    rec = 1; we = 1; lat = 1; r = 0;
    amt = (rt > W) ? W : rt;
    case (op)
      OP_ADD, OP_ADDC: begin
        s = rs + rt + ((op == OP_ADDC) ? int'(cin) : 0);
        r = s & MASK; m_c = (s > MASK);
      end
      OP_SUB, OP_SUBC, OP_CMP: begin
        s = (op == OP_SUBC) ? int'(cin) : 0;
        r = (rs - rt - s) & MASK; m_c = (rs < rt + s);
        we = (op != OP_CMP);
      end
      OP_AND: r = rs & rt;
      OP_OR:  r = rs | rt;
      OP_NEG: r = ~rt & MASK;
      OP_LSL, OP_LSLC: begin
        lat = 1 + amt;
        fill = (op == OP_LSLC) && cin;
        if (amt == 0) r = rs;
        else begin
          r = ((rs << amt) | (fill ? (1 << amt) - 1 : 0)) & MASK;
          m_c = ((rs >> (W - amt)) & 1) != 0;
        end
      end
      OP_LSR, OP_LSRC, OP_ASR: begin
        lat = 1 + amt;
        fill = (op == OP_LSRC) ? cin :
               (op == OP_ASR) ? (((rs >> (W - 1)) & 1) != 0) : 0;
        if (amt == 0) r = rs;
        else begin
          r = (rs >> amt) | (fill ? (MASK & ~(MASK >> amt)) : 0);
          m_c = ((rs >> (amt - 1)) & 1) != 0;
        end
      end
`ifdef ALU_ITER_MUL_EN
      OP_MUL: begin
        s = rs * rt; lat = W + 1;
        r = s & MASK; m_c = (s >> W) != 0;
      end
`endif
      default: begin rec = 0; we = 0; r = 0; end
    endcase
    if (rec) begin
      m_n = ((r >> (W - 1)) & 1) != 0;
      m_z = (r == 0);
    end
  endtask

  task automatic run_op(input op_code op, input int rs,
                        input int rt, input bit clr,
                        input bit hold, output int res,
                        output bit we, output int lat);
    bit tmo;
    @(negedge clk);
    chk("ready_idle", ready_o, 1);
    start_i = 1; op_i = op; flag_clr_i = clr;
    rs_i = W'(rs); rt_i = W'(rt);
    @(posedge clk); #1;
    start_i = 0; flag_clr_i = hold;
    op_i = op_code'(8'($urandom));
    rs_i = W'($urandom); rt_i = W'($urandom);
    tmo = 1; lat = 0; res = 0; we = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done_o) begin
        lat = i; res = int'(result_o); we = res_we_o;
        tmo = 0; break;
      end
      chk("ready_busy", ready_o, 0);
    end
    if (tmo) chk("done_timeout", 1, 0);
    @(negedge clk);
    flag_clr_i = 0;
  endtask

  task automatic chk_flags(input string tag);
    chk({tag, "_c"}, carry_o, m_c);
    chk({tag, "_n"}, neg_o, m_n);
    chk({tag, "_z"}, zero_o, m_z);
  endtask

  initial begin
    int r, mr, lat, mlat;
    bit we, mwe, clr;
    op_code op;
    op_code pool[16];

    tbl[0]  = '{OP_ADD,  'hF0, 'h20, 0, 'h10, 1, 0, 0, 1, 1};
    tbl[1]  = '{OP_ADDC, 'h01, 'h00, 0, 'h02, 0, 0, 0, 1, 1};
    tbl[2]  = '{OP_SUB,  'h05, 'h07, 0, 'hFE, 1, 1, 0, 1, 1};
    tbl[3]  = '{OP_CMP,  'h33, 'h33, 0, 'h00, 0, 0, 1, 0, 1};
    tbl[4]  = '{OP_LSL,  'h81, 3,    0, 'h08, 0, 0, 0, 1, 4};
    tbl[5]  = '{OP_ASR,  'h80, 9,    0, 'hFF, 1, 1, 0, 1, 9};
    tbl[6]  = '{OP_LSRC, 'h02, 2,    0, 'hC0, 1, 1, 0, 1, 3};
    tbl[7]  = '{OP_LSL,  'h5A, 0,    0, 'h5A, 1, 0, 0, 1, 1};
    tbl[8]  = '{OP_ADDC, 'hFF, 'h00, 1, 'hFF, 0, 1, 0, 1, 1};
    tbl[9]  = '{OP_AND,  'hF0, 'h0F, 0, 'h00, 0, 0, 1, 1, 1};
    tbl[10] = '{OP_OR,   'hF0, 'h0F, 0, 'hFF, 0, 1, 0, 1, 1};
    tbl[11] = '{OP_NEG,  'h00, 'h0F, 0, 'hF0, 0, 1, 0, 1, 1};
    tbl[12] = '{OP_HALT, 'hA5, 'h5A, 0, 'h00, 0, 1, 0, 0, 1};
    tbl[13] = '{OP_SUB,  'h00, 'h01, 0, 'hFF, 1, 1, 0, 1, 1};
    tbl[14] = '{OP_SUBC, 'h10, 'h05, 0, 'h0A, 0, 0, 0, 1, 1};
    tbl[15] = '{OP_ADD,  'hFF, 'h01, 0, 'h00, 1, 0, 1, 1, 1};
    tbl[16] = '{OP_LSLC, 'h01, 2,    0, 'h07, 0, 0, 0, 1, 3};
    tbl[17] = '{OP_LSR,  'h01, 1,    0, 'h00, 1, 0, 1, 1, 2};

    pool = '{OP_ADD, OP_ADDC, OP_SUB, OP_SUBC, OP_CMP,
             OP_AND, OP_OR, OP_NEG, OP_LSL, OP_LSR,
             OP_LSLC, OP_LSRC, OP_ASR, OP_IMME, OP_LW,
             OP_HALT};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", ready_o, 1);
    chk("rst_done", done_o, 0);
    chk("rst_we", res_we_o, 0);
    chk("rst_result", result_o, 0);
    chk_flags("rst");
    reset = 0;

    for (int i = 0; i < 18; i++) begin
      run_op(tbl[i].op, tbl[i].rs, tbl[i].rt, tbl[i].clr,
             0, r, we, lat);
      model_op(tbl[i].op, tbl[i].rs, tbl[i].rt, tbl[i].clr,
               mr, mwe, mlat);
      chk($sformatf("tbl%0d_res", i), r, tbl[i].res);
      chk($sformatf("tbl%0d_we", i), we, tbl[i].we);
      chk($sformatf("tbl%0d_lat", i), lat, tbl[i].lat);
      chk($sformatf("tbl%0d_c", i), carry_o, tbl[i].c);
      chk($sformatf("tbl%0d_n", i), neg_o, tbl[i].n);
      chk($sformatf("tbl%0d_z", i), zero_o, tbl[i].z);
    end

    // clear held through DONE: the ADD flag update must win
    run_op(OP_ADD, 'hF0, 'h20, 1, 1, r, we, lat);
    model_op(OP_ADD, 'hF0, 'h20, 1, mr, mwe, mlat);
    chk("hold_res", r, 'h10);
    chk_flags("hold");

    // clear alone in IDLE
    @(negedge clk); flag_clr_i = 1;
    @(negedge clk); flag_clr_i = 0;
    m_c = 0; m_n = 0; m_z = 0;
    chk_flags("idle_clr");

    // reset in the middle of a long shift
    run_op(OP_SUB, 'h05, 'h07, 0, 0, r, we, lat);
    model_op(OP_SUB, 'h05, 'h07, 0, mr, mwe, mlat);
    chk_flags("pre_rst");
    @(negedge clk);
    start_i = 1; op_i = OP_LSL; rs_i = 8'h01; rt_i = 8'd7;
    @(posedge clk); #1 start_i = 0;
    repeat (3) @(negedge clk);
    chk("mid_busy", ready_o, 0);
    reset = 1; #1;
    m_c = 0; m_n = 0; m_z = 0;
    chk("mid_rst_ready", ready_o, 1);
    chk("mid_rst_done", done_o, 0);
    chk_flags("mid_rst");
    repeat (2) begin
      @(negedge clk);
      chk("rst_hold_ready", ready_o, 1);
      chk("rst_hold_done", done_o, 0);
    end
    reset = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("post_rst_done", done_o, 0);
      chk("post_rst_ready", ready_o, 1);
    end

`ifdef ALU_ITER_MUL_EN
    run_op(OP_MUL, 'h10, 'h20, 0, 0, r, we, lat);
    model_op(OP_MUL, 'h10, 'h20, 0, mr, mwe, mlat);
    chk("mul_res", r, 'h00);
    chk("mul_lat", lat, 9);
    chk("mul_c", carry_o, 1);
    chk("mul_z", zero_o, 1);
`endif

    for (int i = 0; i < 200; i++) begin
      int rs, rt;
      op = pool[$urandom_range(0, 15)];
`ifdef ALU_ITER_MUL_EN
      if ($urandom_range(0, 9) == 0) op = OP_MUL;
`endif
      rs = int'($urandom_range(0, MASK));
      rt = is_shift(op) ? int'($urandom_range(0, 10))
                        : int'($urandom_range(0, MASK));
      clr = ($urandom_range(0, 7) == 0);
      run_op(op, rs, rt, clr, 0, r, we, lat);
      model_op(op, rs, rt, clr, mr, mwe, mlat);
      chk($sformatf("rnd%0d_res", i), r, mr);
      chk($sformatf("rnd%0d_we", i), we, mwe);
      chk($sformatf("rnd%0d_lat", i), lat, mlat);
      chk_flags($sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
